// File: rtl/audio_frame_pingpong_pkg.sv
// Shared types for the ping-pong audio frame loader.
package audio_pkg;

  localparam int DEF_SAMPLE_W = 16;

  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    DRAINING
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } drain_state_t;

  // $clog2 that never returns 0, so single-entry fields still get one bit
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_frame_pingpong_frame_bank.sv
// One frame bank: beat-wide write port and a registered beat read port.
// The read register doubles as the beat register the drain side streams from.
module frame_bank #(
  parameter int BUS_W  = 512,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [BUS_W-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [BUS_W-1:0]  o_rd_data
);

  logic [BUS_W-1:0] r_mem [DEPTH];
  logic [BUS_W-1:0] r_rd_data;

  // Storage is not reset; unwritten beats keep whatever they held before.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered beat read, cleared on reset so the sample output starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/audio_frame_pingpong.sv
// Double-buffered multi-channel audio frame loader.
// Host fills one bank with wide beats while the other streams samples out.
//
// Drain FSM
//   state  | meaning
//   IDLE   | no bank draining; wait for a FULL bank
//   LOAD   | read beat (ch, beat) of the draining bank into its beat register
//   STREAM | present one sample per handshake from the beat register
module audio_frame_pingpong
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W  = 16,
  parameter  int BUS_W     = 512,
  parameter  int FRAME_LEN = 2048,
  parameter  int NUM_CH    = 1,
  localparam int SPB       = BUS_W / SAMPLE_W,
  localparam int BEATS     = FRAME_LEN / SPB,
  localparam int CH_W      = clog2_min1(NUM_CH),
  localparam int BEAT_W    = $clog2(BEATS),
  localparam int SPB_W     = $clog2(SPB),
  localparam int IDX_W     = $clog2(FRAME_LEN),
  localparam int DEPTH     = NUM_CH * BEATS,
  localparam int ADDR_W    = clog2_min1(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [BEAT_W-1:0]   wr_index,
  input  logic [BUS_W-1:0]    wr_data,
  input  logic                commit,
  output logic                host_ready,
  output logic                wr_overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic [CH_W-1:0]     out_ch,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic [15:0]         frames_out
);

  bank_state_t  r_bank_state [2];
  drain_state_t r_state, w_next;
  logic         r_fill_bank, r_drain_bank, r_overflow;
  logic [CH_W-1:0]   r_ch;
  logic [BEAT_W-1:0] r_beat;
  logic [SPB_W-1:0]  r_samp;
  logic [15:0]       r_frames;

  logic w_wr_fire, w_commit_fire, w_other_full, w_fill_full, w_any_full, w_pick_bank;
  logic w_pick, w_load, w_adv, w_release, w_out_valid;
  logic w_samp_end, w_beat_end, w_ch_end, w_frame_end;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [BUS_W-1:0]  w_rd_data [2];
  logic [BUS_W-1:0]  w_beat;

  assign host_ready    = (r_bank_state[r_fill_bank] == EMPTY);
  assign w_wr_fire     = wr_en && host_ready;
  assign w_commit_fire = commit && host_ready;

  // {ch, beat} equals ch*BEATS+beat because BEATS is a power of two
  assign w_wr_addr = ADDR_W'({wr_ch, wr_index});
  assign w_rd_addr = ADDR_W'({r_ch, r_beat});

  // The bank the host is not filling wins if both are FULL.
  assign w_other_full = (r_bank_state[~r_fill_bank] == FULL);
  assign w_fill_full  = (r_bank_state[r_fill_bank] == FULL);
  assign w_any_full   = w_other_full || w_fill_full;
  assign w_pick_bank  = w_other_full ? ~r_fill_bank : r_fill_bank;

  assign w_samp_end  = (r_samp == SPB_W'(SPB - 1));
  assign w_beat_end  = (r_beat == BEAT_W'(BEATS - 1));
  assign w_ch_end    = (r_ch == CH_W'(NUM_CH - 1));
  assign w_frame_end = w_beat_end && w_ch_end;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    frame_bank #(
      .BUS_W (BUS_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wr_en  (w_wr_fire && (r_fill_bank == 1'(g))),
      .i_wr_addr(w_wr_addr),
      .i_wr_data(wr_data),
      .i_rd_en  (w_load && (r_drain_bank == 1'(g))),
      .i_rd_addr(w_rd_addr),
      .o_rd_data(w_rd_data[g])
    );
  end

  assign w_beat      = w_rd_data[r_drain_bank];
  assign out_sample  = w_beat[SAMPLE_W*r_samp +: SAMPLE_W];
  assign out_valid   = w_out_valid;
  assign out_ch      = r_ch;
  assign out_idx     = {r_beat, r_samp};
  assign out_last    = w_out_valid && w_frame_end && w_samp_end;
  assign frames_out  = r_frames;
  assign wr_overflow = r_overflow;

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Drain FSM next state and per-cycle control strobes.
  always_comb begin
    w_next      = r_state;
    w_pick      = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_release   = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_full) begin
          w_pick = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = STREAM;
      end
      STREAM: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_adv = 1'b1;
          if (w_samp_end) begin
            if (w_frame_end) begin
              w_release = 1'b1;
              w_next    = IDLE;
            end else begin
              w_next = LOAD;
            end
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Bank ownership: commit, drain pick and release always target different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_state[0] <= EMPTY;
      r_bank_state[1] <= EMPTY;
      r_fill_bank     <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_commit_fire && (r_fill_bank == 1'(b)))      r_bank_state[b] <= FULL;
        else if (w_pick && (w_pick_bank == 1'(b)))        r_bank_state[b] <= DRAINING;
        else if (w_release && (r_drain_bank == 1'(b)))    r_bank_state[b] <= EMPTY;
      end
      if (w_commit_fire) r_fill_bank <= ~r_fill_bank;
      if ((wr_en || commit) && !host_ready) r_overflow <= 1'b1;
    end
  end

  // Channel-major read pointers and the completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_bank <= 1'b0;
      r_ch         <= '0;
      r_beat       <= '0;
      r_samp       <= '0;
      r_frames     <= '0;
    end else begin
      if (w_pick) begin
        r_drain_bank <= w_pick_bank;
        r_ch         <= '0;
        r_beat       <= '0;
      end
      if (w_load) r_samp <= '0;
      if (w_adv) begin
        r_samp <= r_samp + 1'b1;
        if (w_samp_end) begin
          if (w_beat_end) begin
            r_beat <= '0;
            r_ch   <= w_ch_end ? '0 : r_ch + 1'b1;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
      end
      if (w_release) r_frames <= r_frames + 16'd1;
    end
  end

endmodule

// File: tb/tb_audio_frame_pingpong.sv
// Scoreboard bench: default single-channel instance plus a 2-channel small instance.
module tb_audio_frame_pingpong;
  import audio_pkg::*;

  typedef struct {
    sample_t s;
    int      ch;
    int      idx;
    bit      last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default instance: SPB 32, BEATS 64
  logic         wr_en, commit, out_ready;
  logic [0:0]   wr_ch;
  logic [5:0]   wr_index;
  logic [511:0] wr_data;
  logic         host_ready, wr_overflow, out_valid, out_last;
  logic [15:0]  out_sample, frames_out;
  logic [0:0]   out_ch;
  logic [10:0]  out_idx;

  // small instance: 2 channels, SPB 16, BEATS 4
  logic         wr_en2, commit2, out_ready2;
  logic [0:0]   wr_ch2;
  logic [1:0]   wr_index2;
  logic [255:0] wr_data2;
  logic         host_ready2, wr_overflow2, out_valid2, out_last2;
  logic [15:0]  out_sample2, frames_out2;
  logic [0:0]   out_ch2;
  logic [5:0]   out_idx2;

  audio_frame_pingpong u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_index(wr_index),
    .wr_data(wr_data), .commit(commit), .host_ready(host_ready), .wr_overflow(wr_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample), .out_ch(out_ch),
    .out_idx(out_idx), .out_last(out_last), .frames_out(frames_out)
  );

  audio_frame_pingpong #(.SAMPLE_W(16), .BUS_W(256), .FRAME_LEN(64), .NUM_CH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_ch(wr_ch2), .wr_index(wr_index2),
    .wr_data(wr_data2), .commit(commit2), .host_ready(host_ready2), .wr_overflow(wr_overflow2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sample(out_sample2), .out_ch(out_ch2),
    .out_idx(out_idx2), .out_last(out_last2), .frames_out(frames_out2)
  );

  exp_t q1[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push1(input int base);
    exp_t e;
    for (int i = 0; i < 2048; i++) begin
      e.s = sample_t'(base + i); e.ch = 0; e.idx = i; e.last = (i == 2047);
      q1.push_back(e);
    end
  endtask

  task automatic push2(input int base);
    exp_t e;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 64; i++) begin
        e.s = sample_t'(base + 1000*c + i); e.ch = c; e.idx = i; e.last = (c == 1 && i == 63);
        q2.push_back(e);
      end
  endtask

  task automatic put_beat1(input int idx, input int base);
    @(posedge clk); #1;
    wr_en = 1'b1; commit = 1'b0; wr_ch = 1'b0; wr_index = 6'(idx);
    for (int k = 0; k < 32; k++) wr_data[16*k +: 16] = 16'(base + 32*idx + k);
  endtask

  task automatic write_frame1(input int base);
    for (int i = 0; i < 64; i++) put_beat1(i, base);
  endtask

  task automatic commit1(input int base, input bit accept);
    @(posedge clk); #1;
    wr_en = 1'b0; commit = 1'b1;
    if (accept) push1(base);
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic wait_frames1(input int target, input int budget, input string name);
    int c = 0;
    while (frames_out != 16'(target) && c < budget) begin
      @(posedge clk); #1; c++;
    end
    check(name, frames_out, 64'(target));
  endtask

  // Monitor: compare head of queue on every valid cycle, pop on handshake.
  task automatic monitor();
    exp_t e;
    bit   stall1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall1 = 1'b0;
      end else begin
        if (stall1 && !out_valid) begin
          n_chk++; n_fail++;
          $display("FAIL mon1_valid_drop: got out_valid 0 after stall, required 1");
        end
        if (out_valid) begin
          n_chk++;
          if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL mon1_unexpected: got sample %0d idx %0d, required no output",
                     $signed(out_sample), out_idx);
          end else begin
            e = q1[0];
            if (out_sample !== e.s || out_ch !== 1'(e.ch) || out_idx !== 11'(e.idx) ||
                out_last !== e.last) begin
              n_fail++;
              $display("FAIL mon1_sample: got s=%0d ch=%0d idx=%0d last=%0b, required s=%0d ch=%0d idx=%0d last=%0b",
                       $signed(out_sample), out_ch, out_idx, out_last, e.s, e.ch, e.idx, e.last);
            end
            if (out_ready) void'(q1.pop_front());
          end
        end
        stall1 = out_valid && !out_ready;
        if (out_valid2) begin
          n_chk++;
          if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL mon2_unexpected: got sample %0d idx %0d, required no output",
                     $signed(out_sample2), out_idx2);
          end else begin
            e = q2[0];
            if (out_sample2 !== e.s || out_ch2 !== 1'(e.ch) || out_idx2 !== 6'(e.idx) ||
                out_last2 !== e.last) begin
              n_fail++;
              $display("FAIL mon2_sample: got s=%0d ch=%0d idx=%0d last=%0b, required s=%0d ch=%0d idx=%0d last=%0b",
                       $signed(out_sample2), out_ch2, out_idx2, out_last2, e.s, e.ch, e.idx, e.last);
            end
            if (out_ready2) void'(q2.pop_front());
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk); #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    wr_en = 0; commit = 0; out_ready = 1; wr_ch = 0; wr_index = 0; wr_data = '0;
    wr_en2 = 0; commit2 = 0; out_ready2 = 1; wr_ch2 = 0; wr_index2 = 0; wr_data2 = '0;
    fork
      monitor();
      ready_drv();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_host_ready", host_ready, 1);
    check("rst_overflow", wr_overflow, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_out_ch_idx", {out_ch, out_idx}, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frames_out", frames_out, 0);
    check("rst2_host_ready", host_ready2, 1);
    rst_n = 1'b1;

    // single frame: latency, ordering, bubble per beat
    write_frame1(0);
    commit1(0, 1'b1);
    check("lat_after_e0", out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_e1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_e2", out_valid, 1);
    cnt = 2;
    while (frames_out != 16'd1 && cnt < 3000) begin
      @(posedge clk); #1; cnt++;
    end
    check("frame_cycles", 64'(cnt), 2113);
    check("t1_frames", frames_out, 1);

    // small instance: two channels, beats written out of order
    for (int c = 1; c >= 0; c--)
      for (int b = 3; b >= 0; b--) begin
        @(posedge clk); #1;
        wr_en2 = 1'b1; wr_ch2 = 1'(c); wr_index2 = 2'(b);
        for (int k = 0; k < 16; k++) wr_data2[16*k +: 16] = 16'(500 + 1000*c + 16*b + k);
      end
    @(posedge clk); #1;
    wr_en2 = 1'b0; commit2 = 1'b1; push2(500);
    @(posedge clk); #1;
    commit2 = 1'b0;
    cnt = 0;
    while (frames_out2 != 16'd1 && cnt < 400) begin
      @(posedge clk); #1; cnt++;
    end
    check("mc_frames", frames_out2, 1);
    check("mc_queue_empty", 64'(q2.size()), 0);

    // back-to-back frames A and B
    write_frame1(8192);
    commit1(8192, 1'b1);
    check("t2_ready_after_a", host_ready, 1);
    write_frame1(16384);
    commit1(16384, 1'b1);
    check("t2_ready_drop", host_ready, 0);
    wait_frames1(3, 5000, "t2_frames");
    check("t2_queue_empty", 64'(q1.size()), 0);
    check("t2_overflow", wr_overflow, 0);
    check("t2_ready_back", host_ready, 1);

    // overflow: third frame while both banks are busy
    write_frame1(4000);
    commit1(4000, 1'b1);
    write_frame1(12000);
    commit1(12000, 1'b1);
    check("t3_pre_overflow", wr_overflow, 0);
    put_beat1(5, -20000);
    commit = 1'b1;
    put_beat1(6, -20000);
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("t3_overflow", wr_overflow, 1);
    check("t3_ready", host_ready, 0);
    wait_frames1(5, 5000, "t3_frames");
    check("t3_queue_empty", 64'(q1.size()), 0);
    check("t3_overflow_sticky", wr_overflow, 1);

    // random backpressure
    rand_rdy = 1'b1;
    write_frame1(24000);
    commit1(24000, 1'b1);
    wait_frames1(6, 9000, "t4_frames");
    check("t4_queue_empty", 64'(q1.size()), 0);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // reset in the middle of streaming
    write_frame1(2000);
    commit1(2000, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    cnt = 0;
    while (!out_valid && cnt < 5) begin
      @(posedge clk); #1; cnt++;
    end
    check("t5_streaming", out_valid, 1);
    rst_n = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", host_ready, 1);
    check("t5_rst_frames", frames_out, 0);
    check("t5_rst_overflow", wr_overflow, 0);
    check("t5_rst_idx", out_idx, 0);
    rst_n = 1'b1;
    write_frame1(300);
    commit1(300, 1'b1);
    wait_frames1(1, 3000, "t5_fresh_frames");
    check("t5_queue_empty", 64'(q1.size()), 0);
    check("end_q2_empty", 64'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
